audio_frame_scheduler: RTL and testbench
========================================

AUDIO_FRAME_SCHEDULER -- requirements
Module: audio_frame_scheduler

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 6: period counter width is FIFO_WIDTH+1.
REQ-002 SHALL have parameter AUD_BIT_DEPTH, default 24: sample width.
REQ-003 clk  in  1  sole clock; all logic on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 address  in  3  CSR word address.
REQ-006 read / write  in  1 each  CSR strobes.
REQ-007 writedata / readdata  in / out  32 each  CSR data.
REQ-008 frame_tick  in  1  one-cycle pulse per audio frame, already synchronous to clk.
REQ-009 l_data / r_data  in  AUD_BIT_DEPTH each  left/right FIFO output; valid one cycle after rdreq.
REQ-010 l_empty / r_empty  in  1 each  FIFO empty flags.
REQ-011 l_rdreq / r_rdreq  out  1 each  FIFO pop strobes.
REQ-012 out_data  out  32  sample, MSB-justified, low bits zero.
REQ-013 out_chan  out  1  0 = left, 1 = right.
REQ-014 out_valid / out_ready  out / in  1 each  valid/ready handshake.
REQ-015 irq  out  1  level; irq_pending AND irq_en.

Function
REQ-016 CSRs: 0 CTRL rw (bit0 enable, bit1 irq_en); 1 PERIOD rw (frames per period, FIFO_WIDTH+1 bits); 2 STATUS (bit0 busy ro, bit1 irq_pending, bit2 underrun, bit3 late; bits1-3 write-1-to-clear); 3 FRAME_COUNT ro.
REQ-017 readdata SHALL be registered, valid the cycle after read; unmapped addresses read 0, writes to them ignored.
REQ-018 States: IDLE, WAIT_TICK, POP, CAPTURE, SEND_L, SEND_R.
REQ-019 IDLE -> WAIT_TICK when enable=1 and PERIOD!=0; active period length latched then and at each period boundary, so PERIOD writes take effect only there.
REQ-020 WAIT_TICK with enable=0 -> IDLE; frame_count cleared.
REQ-021 WAIT_TICK on frame_tick, both FIFOs non-empty -> POP: l_rdreq and r_rdreq high for exactly that one cycle, then CAPTURE registers l_data/r_data.
REQ-022 frame_tick with either FIFO empty: no pop, both samples forced to 0, underrun set, -> SEND_L.
REQ-023 SEND_L: out_valid=1, out_chan=0, out_data[31:32-AUD_BIT_DEPTH]=left; held stable until out_ready; on handshake -> SEND_R (right, out_chan=1).
REQ-024 SEND_R handshake: frame_count+1; if it equals the latched period, frame_count=0 and irq_pending set; -> WAIT_TICK.
REQ-025 frame_tick in any state other than WAIT_TICK SHALL be dropped and set late.
REQ-026 enable cleared mid-frame: current frame completes both handshakes, then WAIT_TICK -> IDLE.
REQ-027 W1C clear and hardware set of the same STATUS bit in one cycle: set wins.
REQ-028 busy=1 in every state except IDLE.
REQ-029 rdreq SHALL never assert while the corresponding empty=1.

Reset
REQ-030 reset SHALL force IDLE; CTRL, PERIOD, STATUS, frame_count, readdata, out_data, out_chan, out_valid, l_rdreq, r_rdreq, irq all 0.
REQ-031 reset mid-handshake SHALL drop out_valid immediately (asynchronous); no FIFO pop SHALL occur in the cycle reset deasserts.

Verification
REQ-032 PERIOD=4, enable=1, irq_en=1, FIFOs hold L=0x000001..4, R=0x100001..4, out_ready=1, 4 ticks -> 8 beats L,R alternating, out_data=0x00000100 for first L, irq high after 8th beat, FRAME_COUNT=0.
REQ-033 l_empty=1 at tick -> no rdreq, beats out_data=0 on both channels, STATUS bit2=1; write 0x4 to STATUS -> bit2=0.
REQ-034 out_ready=0 for 10 cycles in SEND_L, second tick injected -> out_data stable, late=1, only one frame emitted.
REQ-035 PERIOD changed 4->2 after frame 2 of 4 -> irq after frame 4, next irq after 2 further frames.
REQ-036 enable cleared during SEND_L -> both beats complete, then busy=0 within 2 cycles; further ticks produce no rdreq.
REQ-037 reset asserted during SEND_R -> out_valid=0 same cycle, all CSRs read 0 after release.

Source files
------------

// File: rtl/audio_frame_scheduler_if.sv
// CSR bus and outgoing sample stream of the audio frame scheduler.
// The scheduler sits on the slave side; the host/sink sits on the master side.
interface audio_frame_scheduler_if;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] out_data;
  logic        out_chan;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output address, read, write, writedata, out_ready,
    input  readdata, out_data, out_chan, out_valid
  );

  modport slave (
    input  address, read, write, writedata, out_ready,
    output readdata, out_data, out_chan, out_valid
  );
endinterface

// File: rtl/audio_frame_scheduler.sv
// Pops one left/right sample pair per audio frame tick and streams it as two
// MSB-justified beats (left then right); CSRs count frames per period and raise irq.
module audio_frame_scheduler #(
  parameter int FIFO_WIDTH    = 6,
  parameter int AUD_BIT_DEPTH = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  audio_frame_scheduler_if.slave   bus,
  input  logic                     frame_tick,
  input  logic [AUD_BIT_DEPTH-1:0] l_data,
  input  logic [AUD_BIT_DEPTH-1:0] r_data,
  input  logic                     l_empty,
  input  logic                     r_empty,
  output logic                     l_rdreq,
  output logic                     r_rdreq,
  output logic                     irq
);
  localparam int CW = FIFO_WIDTH + 1;

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_PERIOD = 3'd1;
  localparam logic [2:0] A_STATUS = 3'd2;
  localparam logic [2:0] A_FCOUNT = 3'd3;

  typedef enum logic [2:0] {
    IDLE, WAIT_TICK, POP, CAPTURE, SEND_L, SEND_R
  } state_t;

  state_t state, state_nxt;

  logic          ctrl_en, ctrl_irq_en;
  logic [CW-1:0] period_reg, period_act, frame_count, fc_inc;
  logic          st_irq, st_underrun, st_late;
  logic          busy;

  logic signed [AUD_BIT_DEPTH-1:0] l_samp_p0, r_samp_p0;

  logic latch_period, fc_clear, frame_done, underrun_set, late_set;
  logic zero_samp, capture, pop_c, out_valid_c, out_chan_c, irq_set;
  logic wr_ctrl, wr_period, wr_status;
  logic [31:0] rd_mux;
  logic unused_wdata;

  function automatic logic [31:0] msb_justify(input logic signed [AUD_BIT_DEPTH-1:0] s);
    logic [31:0] r;
    r = '0;
    r[31 -: AUD_BIT_DEPTH] = s;
    return r;
  endfunction

  assign wr_ctrl      = bus.write && (bus.address == A_CTRL);
  assign wr_period    = bus.write && (bus.address == A_PERIOD);
  assign wr_status    = bus.write && (bus.address == A_STATUS);
  assign unused_wdata = ^bus.writedata;

  assign busy    = (state != IDLE);
  assign fc_inc  = frame_count + 1'b1;
  assign irq_set = frame_done && (fc_inc == period_act);
  assign irq     = st_irq & ctrl_irq_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    pop_c        = 1'b0;
    out_valid_c  = 1'b0;
    out_chan_c   = 1'b0;
    latch_period = 1'b0;
    fc_clear     = 1'b0;
    frame_done   = 1'b0;
    underrun_set = 1'b0;
    zero_samp    = 1'b0;
    capture      = 1'b0;
    late_set     = frame_tick && (state != WAIT_TICK);
    case (state)
      IDLE: begin
        if (ctrl_en && (period_reg != '0)) begin
          state_nxt    = WAIT_TICK;
          latch_period = 1'b1;
        end
      end
      WAIT_TICK: begin
        if (!ctrl_en) begin
          state_nxt = IDLE;
          fc_clear  = 1'b1;
        end else if (frame_tick) begin
          if (!l_empty && !r_empty) begin
            state_nxt = POP;
          end else begin
            underrun_set = 1'b1;
            zero_samp    = 1'b1;
            state_nxt    = SEND_L;
          end
        end
      end
      POP: begin
        // Gated by the flags again so a pop can never hit an empty FIFO.
        pop_c     = !l_empty && !r_empty;
        state_nxt = CAPTURE;
      end
      CAPTURE: begin
        capture   = 1'b1;
        state_nxt = SEND_L;
      end
      SEND_L: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_nxt = SEND_R;
      end
      SEND_R: begin
        out_valid_c = 1'b1;
        out_chan_c  = 1'b1;
        if (bus.out_ready) begin
          frame_done = 1'b1;
          state_nxt  = WAIT_TICK;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign l_rdreq       = pop_c;
  assign r_rdreq       = pop_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_chan  = out_chan_c;
  assign bus.out_data  = (state == SEND_L) ? msb_justify(l_samp_p0) :
                         (state == SEND_R) ? msb_justify(r_samp_p0) : '0;

  // Stage p0: FIFO read data, valid the cycle after the pop, lands in the sample registers.
  always_ff @(posedge clk) begin
    if (capture) begin
      l_samp_p0 <= $signed(l_data);
      r_samp_p0 <= $signed(r_data);
    end else if (zero_samp) begin
      l_samp_p0 <= '0;
      r_samp_p0 <= '0;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      A_CTRL:   rd_mux = {30'd0, ctrl_irq_en, ctrl_en};
      A_PERIOD: rd_mux = 32'(period_reg);
      A_STATUS: rd_mux = {28'd0, st_late, st_underrun, st_irq, busy};
      A_FCOUNT: rd_mux = 32'(frame_count);
      default:  rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_en      <= 1'b0;
      ctrl_irq_en  <= 1'b0;
      period_reg   <= '0;
      period_act   <= '0;
      frame_count  <= '0;
      st_irq       <= 1'b0;
      st_underrun  <= 1'b0;
      st_late      <= 1'b0;
      bus.readdata <= '0;
    end else begin
      if (wr_ctrl)   {ctrl_irq_en, ctrl_en} <= bus.writedata[1:0];
      if (wr_period) period_reg <= bus.writedata[CW-1:0];
      // Hardware set is ORed in after the write-1-to-clear so it wins a same-cycle collision.
      st_irq      <= (st_irq      & ~(wr_status & bus.writedata[1])) | irq_set;
      st_underrun <= (st_underrun & ~(wr_status & bus.writedata[2])) | underrun_set;
      st_late     <= (st_late     & ~(wr_status & bus.writedata[3])) | late_set;
      if (latch_period || irq_set) period_act <= period_reg;
      if (fc_clear)       frame_count <= '0;
      else if (irq_set)   frame_count <= '0;
      else if (frame_done) frame_count <= fc_inc;
      if (bus.read) bus.readdata <= rd_mux;
    end
  end
endmodule

// File: tb/tb_audio_frame_scheduler.sv
// Directed + randomized bench for audio_frame_scheduler with a frame-level reference model.
module tb_audio_frame_scheduler;
  localparam int FW = 6;
  localparam int BD = 24;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          frame_tick = 1'b0;
  logic [BD-1:0] l_data, r_data;
  logic          l_empty, r_empty, l_rdreq, r_rdreq, irq;

  audio_frame_scheduler_if bus();

  audio_frame_scheduler #(.FIFO_WIDTH(FW), .AUD_BIT_DEPTH(BD)) dut (
    .clk(clk), .reset(reset), .bus(bus), .frame_tick(frame_tick),
    .l_data(l_data), .r_data(r_data), .l_empty(l_empty), .r_empty(r_empty),
    .l_rdreq(l_rdreq), .r_rdreq(r_rdreq), .irq(irq)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // FIFO model: initial block owns write side, FIFO process owns read side.
  logic [BD-1:0] lmem [64];
  logic [BD-1:0] rmem [64];
  int lw = 0, lr = 0, rw = 0, rr = 0;
  assign l_empty = (lw == lr);
  assign r_empty = (rw == rr);

  always @(posedge clk) begin
    if (l_rdreq && (lw != lr)) begin l_data <= lmem[lr]; lr <= lr + 1; end
    if (r_rdreq && (rw != rr)) begin r_data <= rmem[rr]; rr <= rr + 1; end
  end

  // Sink ready: 0 = held low, 1 = held high, 2 = random per cycle.
  int   rdy_mode = 0;
  logic rnd_rdy = 1'b0;
  always @(posedge clk) rnd_rdy <= 1'($urandom_range(0, 1));
  always_comb bus.out_ready = (rdy_mode == 2) ? rnd_rdy : (rdy_mode == 1);

  // Beat and pop monitor, sampled mid-cycle.
  logic [32:0] obs_mem [256];
  int ow = 0, orr = 0;
  int rd_cnt = 0, rd_bad = 0;
  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      obs_mem[ow] <= {bus.out_chan, bus.out_data};
      ow <= ow + 1;
    end
    if (l_rdreq || r_rdreq) rd_cnt <= rd_cnt + 1;
    if ((l_rdreq && l_empty) || (r_rdreq && r_empty)) rd_bad <= rd_bad + 1;
  end

  // Reference model state.
  logic [32:0] exp_q[$];
  int m_fc = 0, m_active = 0, m_period = 0;
  bit m_pend = 0, m_under = 0, m_late = 0, m_irq_en = 0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus.address = a; bus.writedata = d; bus.write = 1'b1;
    @(posedge clk); #1;
    bus.write = 1'b0;
  endtask

  task automatic csr_read(input logic [2:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    bus.address = a; bus.read = 1'b1;
    @(posedge clk); #1;
    bus.read = 1'b0;
    d = bus.readdata;
  endtask

  task automatic push_l(input logic [BD-1:0] v); lmem[lw] = v; lw++; endtask
  task automatic push_r(input logic [BD-1:0] v); rmem[rw] = v; rw++; endtask

  task automatic do_tick();
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
  endtask

  task automatic model_tick();
    logic [BD-1:0] l, r;
    if ((lw != lr) && (rw != rr)) begin l = lmem[lr]; r = rmem[rr]; end
    else begin l = '0; r = '0; m_under = 1; end
    exp_q.push_back({1'b0, l, 8'h00});
    exp_q.push_back({1'b1, r, 8'h00});
  endtask

  task automatic model_frame_done();
    m_fc++;
    if (m_fc == m_active) begin m_fc = 0; m_pend = 1; m_active = m_period; end
  endtask

  task automatic wait_valid(input string tag);
    int cyc = 0;
    while (!bus.out_valid && cyc < 50) begin @(negedge clk); #1; cyc++; end
    check({tag, "_valid"}, bus.out_valid, 1'b1);
  endtask

  task automatic wait_frame(input string tag);
    int cyc = 0;
    while ((ow - orr) < 2 && cyc < 300) begin @(negedge clk); #1; cyc++; end
    check({tag, "_beats"}, (ow - orr) >= 2, 1'b1);
    for (int i = 0; i < 2; i++) begin
      if ((ow - orr) > 0 && exp_q.size() > 0) begin
        check({tag, "_beat"}, obs_mem[orr], exp_q.pop_front());
        orr++;
      end
    end
    @(posedge clk); #1;
    model_frame_done();
    check({tag, "_irq"}, irq, m_pend & m_irq_en);
  endtask

  function automatic logic [31:0] exp_status(input bit busy);
    return {28'd0, m_late, m_under, m_pend, busy};
  endfunction

  initial begin
    logic [31:0] rd;
    int snap;
    bus.address = '0; bus.read = 1'b0; bus.write = 1'b0; bus.writedata = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_irq", irq, 1'b0);
    check("rst_rdreq", {l_rdreq, r_rdreq}, 2'b00);
    check("rst_readdata", bus.readdata, 32'd0);
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      csr_read(3'(a), rd);
      check("rst_csr", rd, 32'd0);
    end

    // Basic period of 4 frames
    csr_write(3'd1, 32'd4); m_period = 4;
    csr_write(3'd0, 32'd3); m_irq_en = 1; m_active = m_period;
    rdy_mode = 1;
    for (int i = 1; i <= 4; i++) begin
      push_l(24'(i)); push_r(24'h100000 + 24'(i));
    end
    check("first_l_expect", exp_q.size(), 0);
    for (int i = 0; i < 4; i++) begin
      model_tick();
      do_tick();
      wait_frame("basic");
    end
    check("basic_irq_hi", irq, 1'b1);
    csr_read(3'd3, rd);
    check("basic_fcount", rd, 32'd0);
    csr_write(3'd2, 32'h2); m_pend = 0;
    check("basic_irq_clr", irq, 1'b0);

    // Randomized frames with random stalls and occasional underruns
    rdy_mode = 2;
    for (int f = 0; f < 12; f++) begin
      int kind = $urandom_range(0, 3);
      if (kind >= 2) begin push_l(24'($urandom)); push_r(24'($urandom)); end
      else if (kind == 1) push_r(24'($urandom));
      model_tick();
      do_tick();
      wait_frame("rand");
    end
    csr_read(3'd2, rd);
    check("rand_status", rd, exp_status(1));
    csr_read(3'd3, rd);
    check("rand_fcount", rd, 32'(m_fc));

    // Left FIFO empty at tick
    csr_write(3'd2, 32'hE); m_pend = 0; m_under = 0; m_late = 0;
    snap = rd_cnt;
    push_r(24'($urandom));
    model_tick();
    do_tick();
    wait_frame("undr");
    check("undr_no_rdreq", rd_cnt, snap);
    csr_read(3'd2, rd);
    check("undr_bit2", rd[2], 1'b1);
    csr_write(3'd2, 32'h4); m_under = 0;
    csr_read(3'd2, rd);
    check("undr_bit2_clr", rd[2], 1'b0);

    // Stall in SEND_L with a late tick
    rdy_mode = 0;
    push_l(24'($urandom)); push_r(24'($urandom));
    model_tick();
    do_tick();
    wait_valid("stall");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1 frame_tick = (i == 4);
      @(negedge clk); #1;
      check("stall_data", {bus.out_chan, bus.out_data}, exp_q[0]);
    end
    m_late = 1;
    csr_read(3'd2, rd);
    check("stall_late", rd[3], 1'b1);
    rdy_mode = 1;
    wait_frame("stall");
    snap = rd_cnt;
    repeat (10) @(posedge clk);
    #1;
    check("stall_one_frame", ow - orr, 0);
    check("stall_no_pop", rd_cnt, snap);

    // Period change 4 -> 2 takes effect only at the boundary
    csr_write(3'd0, 32'h2); m_irq_en = 1; m_fc = 0;
    csr_read(3'd3, rd);
    check("dis_fcount", rd, 32'd0);
    csr_write(3'd2, 32'hE); m_pend = 0; m_under = 0; m_late = 0;
    csr_write(3'd1, 32'd4); m_period = 4;
    csr_write(3'd0, 32'h3); m_active = m_period;
    rdy_mode = 2;
    for (int f = 0; f < 6; f++) begin
      if (f == 2) begin csr_write(3'd1, 32'd2); m_period = 2; end
      if (f == 4) begin
        check("per_irq_f4", irq, 1'b1);
        csr_write(3'd2, 32'h2); m_pend = 0;
      end
      push_l(24'($urandom)); push_r(24'($urandom));
      model_tick();
      do_tick();
      wait_frame("per");
    end
    check("per_irq_f6", irq, 1'b1);

    // Enable cleared during SEND_L
    rdy_mode = 0;
    push_l(24'($urandom)); push_r(24'($urandom));
    model_tick();
    do_tick();
    wait_valid("dis");
    csr_write(3'd0, 32'h2);
    rdy_mode = 1;
    wait_frame("dis");
    m_fc = 0;
    csr_read(3'd2, rd);
    check("dis_busy", rd[0], 1'b0);
    snap = rd_cnt;
    push_l(24'($urandom)); push_r(24'($urandom));
    for (int i = 0; i < 3; i++) do_tick();
    m_late = 1;
    repeat (5) @(posedge clk);
    #1;
    check("dis_no_pop", rd_cnt, snap);
    check("dis_no_beat", ow - orr, 0);
    csr_read(3'd2, rd);
    check("dis_status", rd, exp_status(0));

    // Reset asserted during SEND_R
    csr_write(3'd0, 32'h3); m_active = m_period;
    rdy_mode = 0;
    model_tick();
    do_tick();
    wait_valid("rst");
    @(posedge clk); #1 rdy_mode = 1;
    @(posedge clk); #1 rdy_mode = 0;
    check("rst_sendr", {bus.out_valid, bus.out_chan}, 2'b11);
    check("rst_l_beat", obs_mem[orr], exp_q[0]);
    #2 reset = 1'b1;
    #1;
    check("rst_async_valid", bus.out_valid, 1'b0);
    exp_q.delete();
    orr = ow;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_irq", irq, 1'b0);
    check("rst_hold_rd", bus.readdata, 32'd0);
    reset = 1'b0;
    check("rst_rel_rdreq", {l_rdreq, r_rdreq}, 2'b00);
    for (int a = 0; a < 4; a++) begin
      csr_read(3'(a), rd);
      check("rst_rel_csr", rd, 32'd0);
    end
    check("rdreq_while_empty", rd_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
